game_view_seq: RTL and testbench

Parametrised successor to the view FSM. It sequences one complete screen redraw per frame tick: background, then every object of every class, then every enabled hook, then the number panel. It also runs the start, game-over, next-level and win overlay screens. The block owns the level counter and frame divider, and sits between the game logic (counts, `game_end`, `next_level`) and the draw engines (enable/done handshakes).

---
 rtl/game_view_pkg.sv | 29 ++
 rtl/game_view_seq_frame_tick.sv | 27 ++
 rtl/game_view_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_game_view_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_view_pkg.sv
// Shared constants for the screen-redraw sequencer: FSM state codes, overlay selects, frame divider default.
package game_view_pkg;

  localparam int unsigned DEFAULT_FRAME_DIV = 833334;
  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] ST_START      = 4'd0;
  localparam logic [STATE_W-1:0] ST_SCR_START  = 4'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_START = 4'd2;
  localparam logic [STATE_W-1:0] ST_GENERATE   = 4'd3;
  localparam logic [STATE_W-1:0] ST_BG         = 4'd4;
  localparam logic [STATE_W-1:0] ST_OBJ        = 4'd5;
  localparam logic [STATE_W-1:0] ST_HOOK       = 4'd6;
  localparam logic [STATE_W-1:0] ST_NUM        = 4'd7;
  localparam logic [STATE_W-1:0] ST_GAME       = 4'd8;
  localparam logic [STATE_W-1:0] ST_SCR_OVER   = 4'd9;
  localparam logic [STATE_W-1:0] ST_WAIT_OVER  = 4'd10;
  localparam logic [STATE_W-1:0] ST_SCR_NEXT   = 4'd11;
  localparam logic [STATE_W-1:0] ST_WAIT_NEXT  = 4'd12;
  localparam logic [STATE_W-1:0] ST_LEVEL_UP   = 4'd13;
  localparam logic [STATE_W-1:0] ST_SCR_WIN    = 4'd14;
  localparam logic [STATE_W-1:0] ST_WAIT_WIN   = 4'd15;

  localparam logic [1:0] SCR_START = 2'd0;
  localparam logic [1:0] SCR_OVER  = 2'd1;
  localparam logic [1:0] SCR_NEXT  = 2'd2;
  localparam logic [1:0] SCR_WIN   = 2'd3;

endpackage

// File: rtl/game_view_seq_frame_tick.sv
// Free-running frame divider; tick is a one-cycle pulse once every FRAME_DIV clocks.
module frame_tick
  import game_view_pkg::*;
#(
  parameter int unsigned FRAME_DIV = DEFAULT_FRAME_DIV
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int unsigned CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/game_view_seq.sv
// Per-frame redraw sequencer (background, objects, hooks, numbers) plus overlay screens and level tracking.
module game_view_seq
  import game_view_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 3,
  parameter int unsigned NUM_HOOKS   = 2,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned LEVEL_W     = 3,
  parameter int unsigned MAX_LEVEL   = 3,
  parameter int unsigned FRAME_DIV   = DEFAULT_FRAME_DIV,
  localparam int unsigned CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int unsigned HK_W  = (NUM_HOOKS > 1) ? $clog2(NUM_HOOKS) : 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         go,
  input  logic [NUM_HOOKS-1:0]         hooks_en,
  input  logic [NUM_CLASSES*CNT_W-1:0] max_obj,
  input  logic                         game_end,
  input  logic                         next_level,
  input  logic                         bg_done,
  input  logic                         obj_done,
  input  logic                         hook_done,
  input  logic                         num_done,
  input  logic                         screen_done,
  output logic                         bg_en,
  output logic                         obj_en,
  output logic                         hook_en,
  output logic                         num_en,
  output logic                         screen_en,
  output logic [CLS_W-1:0]             obj_class,
  output logic [CNT_W-1:0]             obj_idx,
  output logic [HK_W-1:0]              hook_idx,
  output logic [1:0]                   screen_sel,
  output logic                         random_en,
  output logic                         timer_en,
  output logic                         timer_resetn,
  output logic                         rope_resetn,
  output logic                         objects_resetn,
  output logic                         level_up,
  output logic [LEVEL_W-1:0]           level,
  output logic                         frame_overrun
);

  // Lowest class at or above 'from' with a nonzero count; MSB flags a hit.
  function automatic logic [CLS_W:0] find_class(input logic [NUM_CLASSES*CNT_W-1:0] counts, input int from);
    logic [CLS_W:0] r;
    r = '0;
    for (int c = int'(NUM_CLASSES) - 1; c >= 0; c--)
      if (c >= from && counts[c*int'(CNT_W) +: CNT_W] != '0) r = {1'b1, CLS_W'(c)};
    return r;
  endfunction

  // Lowest set hook bit at or above 'from'; MSB flags a hit.
  function automatic logic [HK_W:0] find_hook(input logic [NUM_HOOKS-1:0] hooks, input int from);
    logic [HK_W:0] r;
    r = '0;
    for (int h = int'(NUM_HOOKS) - 1; h >= 0; h--)
      if (h >= from && hooks[h]) r = {1'b1, HK_W'(h)};
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] count_of(input logic [NUM_CLASSES*CNT_W-1:0] counts, input logic [CLS_W-1:0] cls);
    return counts[int'(cls)*int'(CNT_W) +: CNT_W];
  endfunction

  logic [STATE_W-1:0]   state, state_nx;
  logic                 go_q, go_d, go_rise, tick, frame_pend, last_level;
  logic [NUM_HOOKS-1:0] hooks_lat, hooks_nx;
  logic [CNT_W-1:0]     cur_cnt, cnt_nx, idx_nx;
  logic [CLS_W-1:0]     cls_nx;
  logic [HK_W-1:0]      hk_nx;
  logic [CLS_W:0]       first_cls, next_cls;
  logic [HK_W:0]        first_hk, next_hk;
  logic [1:0]           sel_nx;

  assign go_rise    = go_q & ~go_d;
  assign last_level = (level == LEVEL_W'(MAX_LEVEL));

  frame_tick #(.FRAME_DIV(FRAME_DIV)) u_frame_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_START;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cls_nx    = obj_class;
    idx_nx    = obj_idx;
    cnt_nx    = cur_cnt;
    hk_nx     = hook_idx;
    hooks_nx  = hooks_lat;
    sel_nx    = screen_sel;
    first_cls = find_class(max_obj, 0);
    next_cls  = find_class(max_obj, int'(obj_class) + 1);
    first_hk  = find_hook(hooks_lat, 0);
    next_hk   = find_hook(hooks_lat, int'(hook_idx) + 1);
    case (state)
      ST_START:      state_nx = ST_SCR_START;
      ST_SCR_START:  if (screen_done) state_nx = ST_WAIT_START;
      ST_WAIT_START: if (go_rise) state_nx = ST_GENERATE;
      ST_GENERATE: begin
        hooks_nx = hooks_en;
        if (go_rise) state_nx = ST_BG;
      end
      ST_BG: if (bg_done) begin
        if (first_cls[CLS_W]) begin
          state_nx = ST_OBJ;
          cls_nx   = first_cls[CLS_W-1:0];
          idx_nx   = '0;
          cnt_nx   = count_of(max_obj, first_cls[CLS_W-1:0]);
        end else if (first_hk[HK_W]) begin
          state_nx = ST_HOOK;
          hk_nx    = first_hk[HK_W-1:0];
        end else state_nx = ST_NUM;
      end
      ST_OBJ: if (obj_done) begin
        if (obj_idx != cur_cnt - CNT_W'(1)) idx_nx = obj_idx + CNT_W'(1);
        else begin
          idx_nx = '0;
          if (next_cls[CLS_W]) begin
            cls_nx = next_cls[CLS_W-1:0];
            cnt_nx = count_of(max_obj, next_cls[CLS_W-1:0]);
          end else if (first_hk[HK_W]) begin
            state_nx = ST_HOOK;
            hk_nx    = first_hk[HK_W-1:0];
          end else state_nx = ST_NUM;
        end
      end
      ST_HOOK: if (hook_done) begin
        if (next_hk[HK_W]) hk_nx = next_hk[HK_W-1:0];
        else               state_nx = ST_NUM;
      end
      ST_NUM: if (num_done) state_nx = ST_GAME;
      ST_GAME: begin
        if (game_end && !next_level)     state_nx = ST_SCR_OVER;
        else if (game_end && last_level) state_nx = ST_SCR_WIN;
        else if (game_end)               state_nx = ST_SCR_NEXT;
        else if (frame_pend)             state_nx = ST_BG;
      end
      ST_SCR_OVER:  if (screen_done) state_nx = ST_WAIT_OVER;
      ST_WAIT_OVER: if (go_rise) state_nx = ST_START;
      ST_SCR_NEXT:  if (screen_done) state_nx = ST_WAIT_NEXT;
      ST_WAIT_NEXT: if (go_rise) state_nx = ST_LEVEL_UP;
      ST_LEVEL_UP:  state_nx = ST_BG;
      ST_SCR_WIN:   if (screen_done) state_nx = ST_WAIT_WIN;
      ST_WAIT_WIN:  if (go_rise) state_nx = ST_START;
      default:      state_nx = ST_START;
    endcase
    case (state_nx)
      ST_START, ST_SCR_START, ST_WAIT_START: sel_nx = SCR_START;
      ST_SCR_OVER, ST_WAIT_OVER:             sel_nx = SCR_OVER;
      ST_SCR_NEXT, ST_WAIT_NEXT:             sel_nx = SCR_NEXT;
      ST_SCR_WIN, ST_WAIT_WIN:               sel_nx = SCR_WIN;
      default:                               sel_nx = screen_sel;
    endcase
  end

  // Iteration registers, level, frame bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      go_q          <= 1'b0;
      go_d          <= 1'b0;
      hooks_lat     <= '0;
      obj_class     <= '0;
      obj_idx       <= '0;
      cur_cnt       <= '0;
      hook_idx      <= '0;
      level         <= LEVEL_W'(1);
      frame_pend    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      go_q      <= go;
      go_d      <= go_q;
      hooks_lat <= hooks_nx;
      obj_class <= cls_nx;
      obj_idx   <= idx_nx;
      cur_cnt   <= cnt_nx;
      hook_idx  <= hk_nx;
      if (state == ST_START) level <= LEVEL_W'(1);
      else if (state_nx == ST_LEVEL_UP && !last_level) level <= level + LEVEL_W'(1);
      // A tick in the same cycle as GAME->BG consumption keeps the flag set.
      if (tick) frame_pend <= 1'b1;
      else if (state == ST_GAME && state_nx == ST_BG) frame_pend <= 1'b0;
      if (state == ST_START) frame_overrun <= 1'b0;
      else if (tick && frame_pend && state != ST_GAME) frame_overrun <= 1'b1;
    end
  end

  // Moore outputs registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bg_en          <= 1'b0;
      obj_en         <= 1'b0;
      hook_en        <= 1'b0;
      num_en         <= 1'b0;
      screen_en      <= 1'b0;
      screen_sel     <= SCR_START;
      random_en      <= 1'b0;
      timer_en       <= 1'b0;
      timer_resetn   <= 1'b0;
      rope_resetn    <= 1'b0;
      objects_resetn <= 1'b0;
      level_up       <= 1'b0;
    end else begin
      bg_en          <= (state_nx == ST_BG);
      obj_en         <= (state_nx == ST_OBJ);
      hook_en        <= (state_nx == ST_HOOK);
      num_en         <= (state_nx == ST_NUM);
      screen_en      <= state_nx inside {ST_SCR_START, ST_SCR_OVER, ST_SCR_NEXT, ST_SCR_WIN};
      screen_sel     <= sel_nx;
      random_en      <= (state_nx == ST_GENERATE);
      timer_en       <= state_nx inside {ST_BG, ST_OBJ, ST_HOOK, ST_NUM, ST_GAME};
      timer_resetn   <= !(state_nx inside {ST_START, ST_GENERATE, ST_SCR_OVER, ST_WAIT_OVER,
                                           ST_SCR_NEXT, ST_WAIT_NEXT});
      rope_resetn    <= !(state_nx inside {ST_START, ST_GENERATE, ST_SCR_OVER, ST_WAIT_OVER,
                                           ST_SCR_NEXT, ST_WAIT_NEXT});
      objects_resetn <= !(state_nx inside {ST_START, ST_GAME, ST_SCR_OVER, ST_WAIT_OVER,
                                           ST_SCR_NEXT, ST_WAIT_NEXT});
      level_up       <= (state_nx == ST_LEVEL_UP);
    end
  end

endmodule

// File: tb/tb_game_view_seq.sv
// Directed bench for game_view_seq: cycle table for the first redraw, then hand sequences for screens, levels, overrun, reset.
module tb_game_view_seq;
  import game_view_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, go, game_end, next_level;
  logic        bg_done, obj_done, hook_done, num_done, screen_done;
  logic [1:0]  hooks_en;
  logic [14:0] max_obj;
  logic        bg_en, obj_en, hook_en, num_en, screen_en;
  logic [1:0]  obj_class;
  logic [4:0]  obj_idx;
  logic [0:0]  hook_idx;
  logic [1:0]  screen_sel;
  logic        random_en, timer_en, timer_resetn, rope_resetn, objects_resetn, level_up, frame_overrun;
  logic [2:0]  level;

  game_view_seq #(.NUM_CLASSES(3), .NUM_HOOKS(2), .CNT_W(5), .LEVEL_W(3), .MAX_LEVEL(3), .FRAME_DIV(64)) dut (
    .clk(clk), .resetn(resetn), .go(go), .hooks_en(hooks_en), .max_obj(max_obj),
    .game_end(game_end), .next_level(next_level),
    .bg_done(bg_done), .obj_done(obj_done), .hook_done(hook_done), .num_done(num_done),
    .screen_done(screen_done),
    .bg_en(bg_en), .obj_en(obj_en), .hook_en(hook_en), .num_en(num_en), .screen_en(screen_en),
    .obj_class(obj_class), .obj_idx(obj_idx), .hook_idx(hook_idx), .screen_sel(screen_sel),
    .random_en(random_en), .timer_en(timer_en), .timer_resetn(timer_resetn),
    .rope_resetn(rope_resetn), .objects_resetn(objects_resetn), .level_up(level_up),
    .level(level), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  // in = {go, screen_done, bg_done, obj_done, hook_done, num_done}; en = {bg, obj, hook, num, screen}; rt = {random, timer}
  typedef struct packed {
    logic [5:0] in;
    logic [4:0] en;
    logic [1:0] rt;
    logic [1:0] cls;
    logic [4:0] idx;
    logic       hk;
    logic [1:0] sel;
  } vec_t;

  vec_t        tbl[20];
  vec_t        t;
  logic [16:0] e, a;
  int          errors = 0;
  int          checks = 0;
  int          nobj, nhook;
  bit          ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic pick(input int s);
    case (s)
      0: return bg_en;
      1: return obj_en;
      2: return hook_en;
      3: return num_en;
      4: return screen_en;
      default: return level_up;
    endcase
  endfunction

  task automatic wait_for(input int s, input int bound, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (pick(s)) begin hit = 1'b1; break; end
    end
  endtask

  task automatic go_pulse();
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
  endtask

  task automatic screen_ack();
    screen_done = 1'b1;
    @(negedge clk); screen_done = 1'b0;
  endtask

  // Level-done engine model: done follows enable; counts object and hook draws until NUM completes.
  task automatic redraw(output int no, output int nh, output bit fin);
    no = 0; nh = 0; fin = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bg_done = bg_en; obj_done = obj_en; hook_done = hook_en; num_done = num_en;
      if (obj_en) no++;
      if (hook_en) nh++;
      if (num_en) begin @(negedge clk); fin = 1'b1; break; end
    end
    bg_done = 1'b0; obj_done = 1'b0; hook_done = 1'b0; num_done = 1'b0;
  endtask

  task automatic level_advance(input int exp_level);
    game_end = 1'b1; next_level = 1'b1;
    wait_for(4, 10, ok);
    chk("next_screen_seen", 32'(ok), 1);
    chk("next_screen_sel", 32'(screen_sel), 2);
    chk("next_resets", 32'({timer_resetn, rope_resetn, objects_resetn}), 0);
    game_end = 1'b0; next_level = 1'b0;
    screen_ack();
    go_pulse();
    wait_for(5, 10, ok);
    chk("level_up_seen", 32'(ok), 1);
    chk("level_after_up", 32'(level), 32'(exp_level));
    @(negedge clk);
    chk("level_up_one_cycle", 32'({level_up, bg_en}), 32'(2'b01));
    redraw(nobj, nhook, ok);
    chk("level_redraw_done", 32'(ok), 1);
    chk("level_redraw_counts", 32'({nobj[7:0], nhook[7:0]}), 32'({8'd5, 8'd2}));
  endtask

  initial begin
    tbl[0]  = '{6'b000000, 5'b00000, 2'b00, 2'd0, 5'd0, 1'b0, 2'd0};
    tbl[1]  = '{6'b010000, 5'b00001, 2'b00, 2'd0, 5'd0, 1'b0, 2'd0};
    tbl[2]  = '{6'b100000, 5'b00000, 2'b00, 2'd0, 5'd0, 1'b0, 2'd0};
    tbl[3]  = '{6'b100000, 5'b00000, 2'b00, 2'd0, 5'd0, 1'b0, 2'd0};
    tbl[4]  = '{6'b100000, 5'b00000, 2'b10, 2'd0, 5'd0, 1'b0, 2'd0};
    tbl[5]  = '{6'b000000, 5'b00000, 2'b10, 2'd0, 5'd0, 1'b0, 2'd0};
    tbl[6]  = '{6'b100000, 5'b00000, 2'b10, 2'd0, 5'd0, 1'b0, 2'd0};
    tbl[7]  = '{6'b000000, 5'b00000, 2'b10, 2'd0, 5'd0, 1'b0, 2'd0};
    tbl[8]  = '{6'b001000, 5'b10000, 2'b01, 2'd0, 5'd0, 1'b0, 2'd0};
    tbl[9]  = '{6'b000000, 5'b01000, 2'b01, 2'd0, 5'd0, 1'b0, 2'd0};
    tbl[10] = '{6'b000100, 5'b01000, 2'b01, 2'd0, 5'd0, 1'b0, 2'd0};
    tbl[11] = '{6'b000100, 5'b01000, 2'b01, 2'd0, 5'd1, 1'b0, 2'd0};
    tbl[12] = '{6'b000100, 5'b01000, 2'b01, 2'd2, 5'd0, 1'b0, 2'd0};
    tbl[13] = '{6'b000100, 5'b01000, 2'b01, 2'd2, 5'd1, 1'b0, 2'd0};
    tbl[14] = '{6'b000100, 5'b01000, 2'b01, 2'd2, 5'd2, 1'b0, 2'd0};
    tbl[15] = '{6'b000010, 5'b00100, 2'b01, 2'd0, 5'd0, 1'b0, 2'd0};
    tbl[16] = '{6'b000010, 5'b00100, 2'b01, 2'd0, 5'd0, 1'b1, 2'd0};
    tbl[17] = '{6'b000001, 5'b00010, 2'b01, 2'd0, 5'd0, 1'b0, 2'd0};
    tbl[18] = '{6'b000000, 5'b00000, 2'b01, 2'd0, 5'd0, 1'b0, 2'd0};
    tbl[19] = '{6'b000000, 5'b00000, 2'b01, 2'd0, 5'd0, 1'b0, 2'd0};

    resetn = 1'b0; go = 1'b0; game_end = 1'b0; next_level = 1'b0;
    bg_done = 1'b0; obj_done = 1'b0; hook_done = 1'b0; num_done = 1'b0; screen_done = 1'b0;
    hooks_en = 2'b11;
    max_obj  = {5'd3, 5'd0, 5'd2};
    repeat (3) @(negedge clk);
    chk("reset_enables", 32'({bg_en, obj_en, hook_en, num_en, screen_en, random_en, timer_en}), 0);
    chk("reset_resets", 32'({timer_resetn, rope_resetn, objects_resetn, level_up, frame_overrun}), 0);
    chk("reset_level", 32'(level), 1);
    resetn = 1'b1;

    // First redraw, cycle by cycle.
    for (int k = 0; k < 20; k++) begin
      t = tbl[k];
      {go, screen_done, bg_done, obj_done, hook_done, num_done} = t.in;
      #1;
      e = {t.en, t.rt, t.en[3] ? t.cls : 2'd0, t.en[3] ? t.idx : 5'd0,
           t.en[2] ? t.hk : 1'b0, t.en[0] ? t.sel : 2'd0};
      a = {bg_en, obj_en, hook_en, num_en, screen_en, random_en, timer_en,
           t.en[3] ? obj_class : 2'd0, t.en[3] ? obj_idx : 5'd0,
           t.en[2] ? hook_idx[0] : 1'b0, t.en[0] ? screen_sel : 2'd0};
      chk($sformatf("vec%0d", k), 32'(a), 32'(e));
      @(negedge clk);
    end
    {go, screen_done, bg_done, obj_done, hook_done, num_done} = 6'b0;
    chk("game_objects_resetn", 32'(objects_resetn), 0);

    level_advance(2);
    level_advance(3);

    // Cleared the last level: win screen, then back to start with level 1.
    game_end = 1'b1; next_level = 1'b1;
    wait_for(4, 10, ok);
    chk("win_screen_seen", 32'(ok), 1);
    chk("win_screen_sel", 32'(screen_sel), 3);
    game_end = 1'b0; next_level = 1'b0;
    screen_ack();
    go_pulse();
    wait_for(4, 10, ok);
    chk("start_after_win", 32'(ok), 1);
    chk("start_sel_level_ovr", 32'({screen_sel, level, frame_overrun}), 32'({2'd0, 3'd1, 1'b0}));

    // Empty round: no objects, no hooks.
    hooks_en = 2'b00;
    max_obj  = '0;
    screen_ack();
    go_pulse();
    repeat (2) @(negedge clk);
    go_pulse();
    redraw(nobj, nhook, ok);
    chk("empty_redraw_done", 32'(ok), 1);
    chk("empty_redraw_counts", 32'({nobj[7:0], nhook[7:0]}), 0);

    // Stalled object draw across several frame ticks.
    max_obj = {5'd3, 5'd0, 5'd2};
    wait_for(0, 200, ok);
    chk("frame_redraw_bg", 32'(ok), 1);
    bg_done = 1'b1;
    @(negedge clk); bg_done = 1'b0;
    wait_for(1, 4, ok);
    chk("stall_obj_seen", 32'(ok), 1);
    repeat (140) @(negedge clk);
    chk("overrun_set", 32'({frame_overrun, obj_en, obj_class, obj_idx}), 32'({1'b1, 1'b1, 2'd0, 5'd0}));
    redraw(nobj, nhook, ok);
    chk("stall_redraw_done", 32'(ok), 1);
    chk("stall_redraw_counts", 32'({nobj[7:0], nhook[7:0]}), 32'({8'd5, 8'd0}));
    chk("overrun_sticky", 32'(frame_overrun), 1);
    game_end = 1'b1; next_level = 1'b0;
    wait_for(4, 10, ok);
    chk("over_screen_seen", 32'(ok), 1);
    chk("over_sel_ovr", 32'({screen_sel, frame_overrun, objects_resetn}), 32'({2'd1, 1'b1, 1'b0}));
    game_end = 1'b0;
    screen_ack();
    go_pulse();
    wait_for(4, 10, ok);
    chk("start_after_over", 32'(ok), 1);
    chk("overrun_cleared", 32'({screen_sel, frame_overrun, level}), 32'({2'd0, 1'b0, 3'd1}));

    // Asynchronous reset in the middle of an object draw.
    hooks_en = 2'b01;
    screen_ack();
    go_pulse();
    repeat (2) @(negedge clk);
    go_pulse();
    wait_for(0, 10, ok);
    chk("rst_bg_seen", 32'(ok), 1);
    bg_done = 1'b1;
    @(negedge clk); bg_done = 1'b0;
    wait_for(1, 4, ok);
    chk("rst_obj_seen", 32'(ok), 1);
    resetn = 1'b0;
    #1;
    chk("rst_enables_drop", 32'({bg_en, obj_en, hook_en, num_en, screen_en, timer_en}), 0);
    chk("rst_timer_level", 32'({timer_resetn, level}), 32'({1'b0, 3'd1}));
    repeat (2) @(negedge clk);
    chk("rst_held", 32'({obj_en, timer_resetn, rope_resetn, level}), 32'({1'b0, 1'b0, 1'b0, 3'd1}));
    resetn = 1'b1;
    wait_for(4, 5, ok);
    chk("rst_restart_screen", 32'({ok, screen_sel}), 32'({1'b1, 2'd0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
